// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among ALU, LOAD and MULDIV,
// with a per-register pending scoreboard that drives the issue-stage hazard signal.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_reg,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_reg,
  input  logic [ADDR_W-1:0]        rd1_reg,
  input  logic [ADDR_W-1:0]        rd2_reg,
  output logic                     hazard,
  output logic [(1<<ADDR_W)-1:0]   pend,
  output logic                     regwrite,
  output logic [ADDR_W-1:0]        wrreg,
  output logic [DATA_W-1:0]        wrdata
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG  = 1 << ADDR_W;

  // Handshake: a requester is accepted in the cycle req_valid[i] & req_ready[i];
  // valid/reg/data stay stable until then, ready is a function of valid and pointer.

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wrreg_q, wrreg_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;

  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic              accept;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    logic found;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
      end
    end
    if (rst) grant = '0;
  end

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel_reg   = req_reg[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];

  always_comb begin
    ptr_d      = ptr_q;
    regwrite_d = 1'b0;
    wrreg_d    = wrreg_q;
    wrdata_d   = wrdata_q;
    pend_d     = pend_q;
    if (accept) begin
      ptr_d      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      regwrite_d = (sel_reg != '0);
      wrreg_d    = sel_reg;
      wrdata_d   = sel_data;
      pend_d[sel_reg] = 1'b0;
    end
    // Reservation is applied after the clear so a same-register collision leaves the bit set.
    if (rsv_valid && rsv_reg != '0) pend_d[rsv_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      pend_q     <= '0;
      regwrite_q <= 1'b0;
      wrreg_q    <= '0;
      wrdata_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      regwrite_q <= regwrite_d;
      wrreg_q    <= wrreg_d;
      wrdata_q   <= wrdata_d;
    end
  end

  assign pend     = pend_q;
  assign regwrite = regwrite_q;
  assign wrreg    = wrreg_q;
  assign wrdata   = wrdata_q;
  assign hazard   = ((rd1_reg != '0) && pend_q[rd1_reg]) ||
                    ((rd2_reg != '0) && pend_q[rd2_reg]);

endmodule
